// File: rtl/fetch_queue_if.sv
// Handshake bundle for fetch_queue: imem request/response, decode output and redirect.
// The DUT takes the master modport; the memory/decode environment takes slave.
interface fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction prefetch queue with redirect flush and in-flight response dropping.
// Optional perf counters are enabled with FETCH_QUEUE_PERF_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master bus
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]   perf_flush_count,
    output logic [15:0]   perf_stall_count
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [PW-1:0]  fill_q, fill_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  pend_q, pend_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [31:0]    pc_q [DEPTH];
    logic [31:0]    pc_d [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [31:0]    data_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;

    logic        req_fire;
    logic        pop;
    logic        resp_fill;
    logic [CW:0] in_use;

    // Outstanding slots include responses still owed to flushed requests.
    assign in_use             = {1'b0, count_q} + {1'b0, drop_q};
    assign bus.imem_req_valid = !reset && !bus.redirect_valid && (in_use < DEPTH_X);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign bus.instr_valid = filled_q[head_q] && !bus.redirect_valid;
    assign bus.instr_data  = (count_q != '0) ? data_q[head_q] : '0;
    assign bus.instr_pc    = (count_q != '0) ? pc_q[head_q] : '0;
    assign pop             = bus.instr_valid && bus.instr_ready;

    assign resp_fill = bus.imem_resp_valid && !bus.redirect_valid
                       && (drop_q == '0) && (pend_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        pc_d       = pc_q;
        data_d     = data_q;
        filled_d   = filled_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            pend_d     = '0;
            filled_d   = '0;
            // Every unfilled entry still owes a response; one arriving now is already consumed.
            drop_d = drop_q + pend_q
                     - CW'(bus.imem_resp_valid && ((drop_q != '0) || (pend_q != '0)));
        end else begin
            if (req_fire) begin
                pc_d[tail_q]     = fetch_pc_q;
                data_d[tail_q]   = '0;
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + 1'b1;
                fetch_pc_d       = fetch_pc_q + 32'd4;
            end
            if (bus.imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (resp_fill) begin
                data_d[fill_q]   = bus.imem_resp_data;
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + 1'b1;
            end
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + 1'b1;
            end
            count_d = count_q + CW'(req_fire) - CW'(pop);
            pend_d  = pend_q + CW'(req_fire) - CW'(resp_fill);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            filled_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            filled_q   <= filled_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.redirect_valid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        if (bus.instr_ready && !bus.instr_valid && !bus.redirect_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_flush_count = flush_cnt_q;
    assign perf_stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle table, directed redirect cases, random scoreboard run.
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    fetch_queue_if bus();
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] perf_flush_count;
    logic [15:0] perf_stall_count;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_flush_count(perf_flush_count),
        .perf_stall_count(perf_stall_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {logic [31:0] addr; int unsigned due;} mreq_t;
    typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
    typedef struct {
        logic rr; logic ir;
        logic rv; logic [31:0] addr; logic iv; logic [31:0] ipc;
    } vec_t;

    mreq_t infl[$];
    exp_t  sb[$];
    int unsigned n_cmp = 0, n_bad = 0, cyc = 0, n_pops = 0;
    int unsigned lat_min = 1, lat_max = 1;
    logic [31:0] model_pc = RESET_PC, last_pop_pc = '0, hold_addr = '0, rpc_now = '0;
    logic hold = 1'b0, resp_now = 1'b0, rd_now = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic rr, input logic ir, input logic rd, input logic [31:0] rpc);
        bus.imem_req_ready = rr;
        bus.instr_ready    = ir;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        rd_now  = rd;
        rpc_now = rpc;
        resp_now = 1'b0;
        bus.imem_resp_data = '0;
        if (infl.size() != 0) begin
            if (infl[0].due <= cyc) begin
                resp_now = 1'b1;
                bus.imem_resp_data = mem_word(infl[0].addr);
            end
        end
        bus.imem_resp_valid = resp_now;
        #1;
    endtask

    task automatic end_cycle();
        logic fire, popd, hold_n;
        logic [31:0] addr_pre;
        fire     = bus.imem_req_valid && bus.imem_req_ready;
        popd     = bus.instr_valid && bus.instr_ready;
        hold_n   = bus.imem_req_valid && !bus.imem_req_ready;
        addr_pre = bus.imem_req_addr;
        if (hold && !rd_now) begin
            chk1("req_hold_valid", bus.imem_req_valid, 1'b1);
            chk32("req_hold_addr", bus.imem_req_addr, hold_addr);
        end
        if (rd_now) begin
            chk1("redirect_req_valid", bus.imem_req_valid, 1'b0);
            chk1("redirect_instr_valid", bus.instr_valid, 1'b0);
        end
        if (fire) chk32("req_addr", bus.imem_req_addr, model_pc);
        if (popd) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_pop: got pc %h expected no instruction", bus.instr_pc);
            end else begin
                chk32("pop_pc", bus.instr_pc, sb[0].pc);
                chk32("pop_data", bus.instr_data, sb[0].data);
            end
            last_pop_pc = bus.instr_pc;
            n_pops++;
        end
        @(posedge clock);
        #1;
        if (resp_now) void'(infl.pop_front());
        if (popd && sb.size() != 0) void'(sb.pop_front());
        if (fire) begin
            infl.push_back('{model_pc, cyc + $urandom_range(lat_max, lat_min)});
            sb.push_back('{model_pc, mem_word(model_pc)});
            model_pc += 32'd4;
        end
        if (rd_now) begin
            sb.delete();
            model_pc = {rpc_now[31:2], 2'b00};
        end
        hold      = hold_n;
        hold_addr = addr_pre;
        cyc++;
    endtask

    task automatic step(input logic rr, input logic ir, input logic rd, input logic [31:0] rpc);
        set_inputs(rr, ir, rd, rpc);
        end_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk1("reset_req_valid", bus.imem_req_valid, 1'b0);
        chk32("reset_req_addr", bus.imem_req_addr, RESET_PC);
        chk1("reset_instr_valid", bus.instr_valid, 1'b0);
        chk32("reset_instr_data", bus.instr_data, 32'h0);
        chk32("reset_instr_pc", bus.instr_pc, 32'h0);
        reset = 1'b0;
        infl.delete();
        sb.delete();
        model_pc = RESET_PC;
        hold     = 1'b0;
        cyc      = 0;
    endtask

    task automatic wait_first_pop(input string name, input logic [31:0] exp_pc);
        int unsigned p0;
        p0 = n_pops;
        for (int k = 0; k < 20 && n_pops == p0; k++) step(1'b1, 1'b1, 1'b0, '0);
        if (n_pops == p0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no instruction within 20 cycles expected pc %h", name, exp_pc);
        end else begin
            chk32(name, last_pop_pc, exp_pc);
        end
    endtask

    initial begin
        vec_t tbl[17];
        int unsigned p0;
        logic rd, prev_rd;

        // rr, ir | req_valid, req_addr, instr_valid, instr_pc   (1-cycle memory)
        tbl = '{
            '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0},
            '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0},
            '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0},
            '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4},
            '{1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h0},
            '{1'b1, 1'b0, 1'b1, 32'h08, 1'b0, 32'h0},
            '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h8},
            '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h8},
            '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h8},
            '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h8},
            '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h8},
            '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h8},
            '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h8},
            '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h8},
            '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h8},
            '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'hC},
            '{1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'hC}
        };

        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_inputs(tbl[i].rr, tbl[i].ir, 1'b0, '0);
            chk1($sformatf("tbl%0d_req_valid", i), bus.imem_req_valid, tbl[i].rv);
            chk32($sformatf("tbl%0d_req_addr", i), bus.imem_req_addr, tbl[i].addr);
            chk1($sformatf("tbl%0d_instr_valid", i), bus.instr_valid, tbl[i].iv);
            chk32($sformatf("tbl%0d_instr_pc", i), bus.instr_pc, tbl[i].ipc);
            end_cycle();
        end

        // Steady state: first pop in cycle 2, then one per cycle.
        do_reset();
        p0 = n_pops;
        repeat (30) step(1'b1, 1'b1, 1'b0, '0);
        chk32("throughput_pops", n_pops - p0, 32'd28);

        // Two requests in flight when redirected.
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        set_inputs(1'b1, 1'b1, 1'b0, '0);
        chk1("post_redirect_req_valid", bus.imem_req_valid, 1'b1);
        chk32("post_redirect_req_addr", bus.imem_req_addr, 32'h0000_0100);
        end_cycle();
        wait_first_pop("redirect_first_pc", 32'h0000_0100);

        // Response lands in the redirect cycle itself.
        do_reset();
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        wait_first_pop("redirect_resp_same_cycle_pc", 32'h0000_0040);

        // Back-to-back redirects with responses arriving during the second.
        do_reset();
        lat_min = 4; lat_max = 4;
        repeat (3) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        wait_first_pop("double_redirect_pc", 32'h0000_0300);

        // Fetch PC wrap.
        do_reset();
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        set_inputs(1'b1, 1'b1, 1'b0, '0);
        chk32("wrap_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
        end_cycle();
        set_inputs(1'b1, 1'b1, 1'b0, '0);
        chk32("wrap_addr1", bus.imem_req_addr, 32'h0000_0000);
        end_cycle();

        // Random traffic with variable latency, redirects and a mid-run reset.
        do_reset();
        lat_min = 1; lat_max = 4;
        prev_rd = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            rd = ($urandom_range(99) < 4) || (prev_rd && ($urandom_range(99) < 30));
            step($urandom_range(99) < 75, $urandom_range(99) < 70, rd, $urandom());
            prev_rd = rd;
        end
        repeat (25) step(1'b0, 1'b1, 1'b0, '0);
        chk32("drain_empty", 32'(sb.size()), 32'd0);

`ifdef FETCH_QUEUE_PERF_EN
        do_reset();
        chk32("perf_flush_reset", {16'h0, perf_flush_count}, 32'd0);
        chk32("perf_stall_reset", {16'h0, perf_stall_count}, 32'd0);
        repeat (5) step(1'b0, 1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0000_0080);
        chk32("perf_flush_count", {16'h0, perf_flush_count}, 32'd3);
        chk32("perf_stall_count", {16'h0, perf_stall_count}, 32'd5);
        do_reset();
        chk32("perf_flush_cleared", {16'h0, perf_flush_count}, 32'd0);
        chk32("perf_stall_cleared", {16'h0, perf_stall_count}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1000000 time units expected $finish");
        $fatal(1, "watchdog expired");
    end
endmodule
